spi_pin_ctrl: RTL and testbench



---
 rtl/spi_pin_ctrl_if.sv | 34 +++
 rtl/spi_pin_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_pin_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pin_ctrl_if.sv
// SPI slave lines plus pin-bank register outputs of the pin controller.
interface spi_pin_ctrl_if #(
    parameter int unsigned NPINS = 5
);
    logic             nCS;
    logic             SCK;
    logic             MOSI;
    logic [NPINS-1:0] pin_out;
    logic [NPINS-1:0] pin_oe;
    logic             frame_done;
    logic             cmd_err;

    // SPI master side: drives the serial lines, observes the pin registers.
    modport master (
        output nCS,
        output SCK,
        output MOSI,
        input  pin_out,
        input  pin_oe,
        input  frame_done,
        input  cmd_err
    );

    // Controller side.
    modport slave (
        input  nCS,
        input  SCK,
        input  MOSI,
        output pin_out,
        output pin_oe,
        output frame_done,
        output cmd_err
    );
endinterface

// File: rtl/spi_pin_ctrl.sv
// SPI-slave command decoder for the pin bank: oversamples nCS/SCK/MOSI in the
// clk domain, parses {opcode, data} frames and updates pin_out / pin_oe.
module spi_pin_ctrl #(
    parameter int unsigned NPINS = 5
) (
    input  logic         clk,
    input  logic         reset,
    spi_pin_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StExec,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic             ncs_meta_q, ncs_q;
    logic             sck_meta_q, sck_q, sck_prev_q;
    logic             mosi_meta_q, mosi_q;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [NPINS-1:0] pin_out_q, pin_out_d;
    logic [NPINS-1:0] pin_oe_q, pin_oe_d;
    logic             frame_done_q, frame_done_d;
    logic             cmd_err_q, cmd_err_d;

    logic             sck_rise;
    logic [7:0]       shift_next;
    logic             opcode_valid;
    logic [NPINS-1:0] data;

    assign sck_rise     = sck_q & ~sck_prev_q;
    assign shift_next   = {shift_q[6:0], mosi_q};
    // Opcodes 0x01..0x07 are the only defined commands.
    assign opcode_valid = (shift_next[7:3] == 5'd0) && (shift_next[2:0] != 3'd0);
    // In StExec the shift register holds the complete data byte.
    assign data         = shift_q[NPINS-1:0];

    // Upper data bits are dropped when fewer than 8 pins are built.
    logic unused_shift;
    assign unused_shift = ^shift_q;

    // Two-flop synchronizers; the extra SCK flop feeds the rising-edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ncs_meta_q  <= 1'b1;
            ncs_q       <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_q       <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            ncs_meta_q  <= bus.nCS;
            ncs_q       <= ncs_meta_q;
            sck_meta_q  <= bus.SCK;
            sck_q       <= sck_meta_q;
            sck_prev_q  <= sck_q;
            mosi_meta_q <= bus.MOSI;
            mosi_q      <= mosi_meta_q;
        end
    end

    // Frame FSM state and pin-bank registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            shift_q      <= 8'd0;
            opcode_q     <= 3'd0;
            pin_out_q    <= '0;
            pin_oe_q     <= '0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            opcode_q     <= opcode_d;
            pin_out_q    <= pin_out_d;
            pin_oe_q     <= pin_oe_d;
            frame_done_q <= frame_done_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // Next-state: bit shifting, opcode decode and command execution.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        opcode_d     = opcode_q;
        pin_out_d    = pin_out_q;
        pin_oe_d     = pin_oe_q;
        frame_done_d = 1'b0;
        cmd_err_d    = 1'b0;

        // Deselect wins over everything, including a coincident 16th edge.
        if (state_q != StIdle && ncs_q) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d   = 3'd0;
                    shift_d = 8'd0;
                    if (!ncs_q) begin
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (opcode_valid) begin
                                opcode_d = shift_next[2:0];
                                state_d  = StData;
                            end else begin
                                cmd_err_d = 1'b1;
                                state_d   = StDrain;
                            end
                        end
                    end
                end
                StData: begin
                    if (sck_rise) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = StExec;
                        end
                    end
                end
                StExec: begin
                    frame_done_d = 1'b1;
                    state_d      = StDrain;
                    case (opcode_q)
                        3'd1:    pin_out_d = data;
                        3'd2:    pin_oe_d  = data;
                        3'd3:    pin_out_d = pin_out_q | data;
                        3'd4:    pin_out_d = pin_out_q & ~data;
                        3'd5:    pin_out_d = pin_out_q ^ data;
                        3'd6:    pin_oe_d  = pin_oe_q | data;
                        3'd7:    pin_oe_d  = pin_oe_q & ~data;
                        default: frame_done_d = 1'b0;
                    endcase
                end
                StDrain: begin
                    // Wait for deselect; trailing SCK edges are ignored.
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.pin_out    = pin_out_q;
    assign bus.pin_oe     = pin_oe_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_pin_ctrl.sv
// Directed bench for spi_pin_ctrl: bit-banged SPI frames, checks of pin
// registers, pulse counts and pulse latency relative to the raw SCK edge.
module tb_spi_pin_ctrl;

    localparam int unsigned NPINS = 5;

    logic clk;
    logic reset;

    spi_pin_ctrl_if #(.NPINS(NPINS)) bus ();

    spi_pin_ctrl #(.NPINS(NPINS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = 0;
    int err_cyc  = 0;
    int rise_cyc = 0;
    int rise_num = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bus.cmd_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send the top n bits of b MSB first; SCK low 5 clk, high 5 clk.
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.MOSI = b[7-i];
            repeat (4) @(negedge clk);
            bus.SCK  = 1'b1;
            rise_cyc = cyc;
            rise_num++;
            repeat (5) @(negedge clk);
            bus.SCK = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.nCS  = 1'b0;
        rise_num = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (3) @(negedge clk);
        bus.nCS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Full two-byte frame; returns the cycle of the raw 16th SCK rise.
    task automatic frame(input logic [7:0] op, input logic [7:0] d, output int last_rise);
        cs_low();
        spi_bits(op, 8);
        spi_bits(d, 8);
        last_rise = rise_cyc;
        cs_high();
    endtask

    int lr;
    int d0;
    int e0;

    initial begin
        reset    = 1'b1;
        bus.nCS  = 1'b1;
        bus.SCK  = 1'b0;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pin_out", 32'(bus.pin_out), 32'h00);
        check_eq("rst_pin_oe", 32'(bus.pin_oe), 32'h00);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("idle_pin_out", 32'(bus.pin_out), 32'h00);
        check_eq("idle_pin_oe", 32'(bus.pin_oe), 32'h00);
        check_eq("idle_done", 32'(done_cnt), 32'd0);
        check_eq("idle_err", 32'(err_cnt), 32'd0);

        // Basic writes; update visible 4 clk after the raw 16th rise.
        frame(8'h02, 8'h1F, lr);
        check_eq("oe_write", 32'(bus.pin_oe), 32'h1F);
        check_eq("oe_latency", 32'(done_cyc - lr), 32'd4);
        frame(8'h01, 8'h15, lr);
        check_eq("out_write", 32'(bus.pin_out), 32'h15);
        check_eq("out_latency", 32'(done_cyc - lr), 32'd4);
        check_eq("done_twice", 32'(done_cnt), 32'd2);

        // Read-modify-write ops.
        frame(8'h03, 8'h0A, lr);
        check_eq("or_out", 32'(bus.pin_out), 32'h1F);
        frame(8'h04, 8'h03, lr);
        check_eq("andn_out", 32'(bus.pin_out), 32'h1C);
        frame(8'h05, 8'hFF, lr);
        check_eq("xor_out_masked", 32'(bus.pin_out), 32'h03);
        frame(8'h07, 8'h11, lr);
        check_eq("andn_oe", 32'(bus.pin_oe), 32'h0E);
        frame(8'h06, 8'h01, lr);
        check_eq("or_oe", 32'(bus.pin_oe), 32'h0F);
        check_eq("oe_keeps_out", 32'(bus.pin_out), 32'h03);
        check_eq("done_seven", 32'(done_cnt), 32'd7);

        // Unknown opcode: single cmd_err 3 clk after the raw 8th rise.
        d0 = done_cnt;
        cs_low();
        spi_bits(8'h09, 8);
        lr = rise_cyc;
        spi_bits(8'h1F, 8);
        cs_high();
        check_eq("err_count", 32'(err_cnt), 32'd1);
        check_eq("err_latency", 32'(err_cyc - lr), 32'd3);
        check_eq("err_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("err_out_kept", 32'(bus.pin_out), 32'h03);
        check_eq("err_oe_kept", 32'(bus.pin_oe), 32'h0F);

        // Partial frame discarded, next frame realigned.
        d0 = done_cnt;
        cs_low();
        spi_bits(8'h01, 8);
        spi_bits(8'h1F, 5);
        cs_high();
        check_eq("partial_out", 32'(bus.pin_out), 32'h03);
        check_eq("partial_done", 32'(done_cnt - d0), 32'd0);
        frame(8'h01, 8'h07, lr);
        check_eq("resync_out", 32'(bus.pin_out), 32'h07);

        // Trailing byte after a frame is ignored.
        d0 = done_cnt;
        cs_low();
        spi_bits(8'h01, 8);
        spi_bits(8'h1F, 8);
        spi_bits(8'h00, 8);
        cs_high();
        check_eq("extra_out", 32'(bus.pin_out), 32'h1F);
        check_eq("extra_done", 32'(done_cnt - d0), 32'd1);

        // SCK activity while deselected does nothing.
        d0 = done_cnt;
        e0 = err_cnt;
        spi_bits(8'h01, 8);
        spi_bits(8'h00, 8);
        repeat (5) @(negedge clk);
        check_eq("desel_out", 32'(bus.pin_out), 32'h1F);
        check_eq("desel_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // Reset mid-frame clears outputs without a clock edge.
        cs_low();
        spi_bits(8'h01, 8);
        spi_bits(8'h1F, 3);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_out", 32'(bus.pin_out), 32'h00);
        check_eq("async_rst_oe", 32'(bus.pin_oe), 32'h00);
        bus.nCS = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post_rst_out", 32'(bus.pin_out), 32'h00);
        frame(8'h01, 8'h05, lr);
        check_eq("restart_out", 32'(bus.pin_out), 32'h05);
        check_eq("restart_latency", 32'(done_cyc - lr), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
